// File: rtl/mpi_credit_tx.sv
// Credit-based flit transmitter: buffers producer flits in a small FIFO and
// forwards them toward the bridge only while downstream credits remain.
module mpi_credit_tx #(
    parameter int DATA_W     = 64,
    parameter int FIFO_DEPTH = 4,
    parameter int CREDITS    = 3
) (
    input  logic              clk_i,
    input  logic              rstn_i,
    input  logic              valid_i,
    input  logic [DATA_W-1:0] data_i,
    output logic              ready_o,
    output logic              valid_o,
    output logic [DATA_W-1:0] data_o,
    input  logic              yummy_i,
    output logic [3:0]        credits_o,
    output logic [31:0]       sent_cnt_o,
    output logic              err_o
);

    localparam int              PTR_W    = $clog2(FIFO_DEPTH);
    localparam logic [PTR_W:0]  FULL_CNT = (PTR_W+1)'(FIFO_DEPTH);
    localparam logic [3:0]      CRED_MAX = 4'(CREDITS);

    // Returns {overflow, next_credits}; a yummy that would exceed the
    // maximum is dropped and flagged instead of wrapping the counter.
    function automatic logic [4:0] credit_next(input logic [3:0] cred,
                                               input logic       snd,
                                               input logic       yum);
        if (yum && !snd && (cred == CRED_MAX))
            return {1'b1, cred};
        return {1'b0, cred - {3'b000, snd} + {3'b000, yum}};
    endfunction

    logic [DATA_W-1:0] mem [FIFO_DEPTH];
    logic [PTR_W-1:0]  rd_ptr;
    logic [PTR_W-1:0]  wr_ptr;
    logic [PTR_W:0]    count;
    logic              push_p0;
    logic              send_p0;
    logic [4:0]        cred_upd_p0;

    assign ready_o     = (count != FULL_CNT);
    assign push_p0     = valid_i && ready_o;
    assign send_p0     = (count != '0) && (credits_o != 4'd0);
    assign cred_upd_p0 = credit_next(credits_o, send_p0, yummy_i);

    // Flit storage carries no reset; occupancy is tracked by count alone.
    always_ff @(posedge clk_i) begin
        if (push_p0)
            mem[wr_ptr] <= data_i;
    end

    // Stage p0 -> registered output toward the bridge
    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            rd_ptr     <= '0;
            wr_ptr     <= '0;
            count      <= '0;
            valid_o    <= 1'b0;
            data_o     <= '0;
            credits_o  <= CRED_MAX;
            sent_cnt_o <= 32'd0;
            err_o      <= 1'b0;
        end else begin
            valid_o   <= send_p0;
            credits_o <= cred_upd_p0[3:0];
            if (cred_upd_p0[4])
                err_o <= 1'b1;
            if (push_p0)
                wr_ptr <= wr_ptr + PTR_W'(1);
            if (send_p0) begin
                data_o     <= mem[rd_ptr];
                rd_ptr     <= rd_ptr + PTR_W'(1);
                sent_cnt_o <= sent_cnt_o + 32'd1;
            end
            unique case ({push_p0, send_p0})
                2'b10:   count <= count + (PTR_W+1)'(1);
                2'b01:   count <= count - (PTR_W+1)'(1);
                default: count <= count;
            endcase
        end
    end

endmodule

// File: tb/tb_mpi_credit_tx.sv
// Self-checking bench for mpi_credit_tx: directed vector table, hand-written
// corner sequences and randomized traffic against a queue-based model.
module tb_mpi_credit_tx;

    localparam int DATA_W     = 64;
    localparam int FIFO_DEPTH = 4;
    localparam int CREDITS    = 3;

    logic              clk_i = 1'b0;
    logic              rstn_i = 1'b0;
    logic              valid_i = 1'b0;
    logic [DATA_W-1:0] data_i = '0;
    logic              ready_o;
    logic              valid_o;
    logic [DATA_W-1:0] data_o;
    logic              yummy_i = 1'b0;
    logic [3:0]        credits_o;
    logic [31:0]       sent_cnt_o;
    logic              err_o;

    mpi_credit_tx #(.DATA_W(DATA_W), .FIFO_DEPTH(FIFO_DEPTH), .CREDITS(CREDITS)) dut (
        .clk_i(clk_i), .rstn_i(rstn_i), .valid_i(valid_i), .data_i(data_i),
        .ready_o(ready_o), .valid_o(valid_o), .data_o(data_o), .yummy_i(yummy_i),
        .credits_o(credits_o), .sent_cnt_o(sent_cnt_o), .err_o(err_o)
    );

    always #5 clk_i = ~clk_i;

    int checks = 0;
    int errors = 0;

    // Reference model: flit queue plus plain integer credit/counter state.
    logic [DATA_W-1:0] mq[$];
    int                mcred;
    logic [31:0]       msent;
    bit                merr;
    bit                mvalid;
    logic [DATA_W-1:0] mdata;

    typedef struct {
        bit                v;
        logic [DATA_W-1:0] d;
        bit                y;
        bit                ev;
        logic [DATA_W-1:0] ed;
        logic [3:0]        ec;
        logic [31:0]       es;
        bit                er;
    } vec_t;

    vec_t tbl[17];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    task automatic model_reset();
        mq.delete();
        mcred  = CREDITS;
        msent  = 32'd0;
        merr   = 1'b0;
        mvalid = 1'b0;
        mdata  = '0;
    endtask

    task automatic model_edge(input bit v, input logic [DATA_W-1:0] d, input bit y);
        bit rdy, snd;
        rdy = mq.size() < FIFO_DEPTH;
        snd = (mq.size() > 0) && (mcred > 0);
        mvalid = snd;
        if (snd) begin
            mdata = mq.pop_front();
            msent = msent + 32'd1;
        end
        if (y && !snd && mcred == CREDITS)
            merr = 1'b1;
        else
            mcred = mcred - int'(snd) + int'(y);
        if (v && rdy)
            mq.push_back(d);
    endtask

    // Called at posedge+1; drives one cycle of inputs and checks the result.
    task automatic cycle(input bit v, input logic [DATA_W-1:0] d, input bit y);
        valid_i = v;
        data_i  = d;
        yummy_i = y;
        #1;
        chk("ready_pre", ready_o, (mq.size() < FIFO_DEPTH));
        @(posedge clk_i);
        model_edge(v, d, y);
        #1;
        chk("valid", valid_o, mvalid);
        chk("data", data_o, mdata);
        chk("credits", credits_o, mcred);
        chk("sent", sent_cnt_o, msent);
        chk("err", err_o, merr);
    endtask

    task automatic do_reset();
        valid_i = 1'b0;
        yummy_i = 1'b0;
        @(negedge clk_i);
        rstn_i = 1'b0;
        model_reset();
        repeat (2) @(negedge clk_i);
        rstn_i = 1'b1;
        @(posedge clk_i);
        #1;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL timeout actual=running required=finished");
        $fatal(1, "timeout");
    end

    initial begin
        int pushed, got, gaps;
        bit started;

        tbl[0]  = '{1, 64'hA0, 0, 0, 64'h0,  4'd3, 32'd0, 1};
        tbl[1]  = '{1, 64'hA1, 0, 1, 64'hA0, 4'd2, 32'd1, 1};
        tbl[2]  = '{1, 64'hA2, 0, 1, 64'hA1, 4'd1, 32'd2, 1};
        tbl[3]  = '{1, 64'hA3, 0, 1, 64'hA2, 4'd0, 32'd3, 1};
        tbl[4]  = '{0, 64'h0,  0, 0, 64'hA2, 4'd0, 32'd3, 1};
        tbl[5]  = '{0, 64'h0,  0, 0, 64'hA2, 4'd0, 32'd3, 1};
        tbl[6]  = '{0, 64'h0,  1, 0, 64'hA2, 4'd1, 32'd3, 1};
        tbl[7]  = '{0, 64'h0,  0, 1, 64'hA3, 4'd0, 32'd4, 1};
        tbl[8]  = '{0, 64'h0,  0, 0, 64'hA3, 4'd0, 32'd4, 1};
        tbl[9]  = '{1, 64'hB0, 0, 0, 64'hA3, 4'd0, 32'd4, 1};
        tbl[10] = '{1, 64'hB1, 0, 0, 64'hA3, 4'd0, 32'd4, 1};
        tbl[11] = '{1, 64'hB2, 0, 0, 64'hA3, 4'd0, 32'd4, 1};
        tbl[12] = '{1, 64'hB3, 0, 0, 64'hA3, 4'd0, 32'd4, 0};
        tbl[13] = '{1, 64'hB4, 0, 0, 64'hA3, 4'd0, 32'd4, 0};
        tbl[14] = '{0, 64'h0,  1, 0, 64'hA3, 4'd1, 32'd4, 0};
        tbl[15] = '{0, 64'h0,  0, 1, 64'hB0, 4'd0, 32'd5, 1};
        tbl[16] = '{0, 64'h0,  0, 0, 64'hB0, 4'd0, 32'd5, 1};

        // Reset state, then five idle cycles
        model_reset();
        #1;
        chk("rst_async_valid", valid_o, 1'b0);
        do_reset();
        for (int i = 0; i < 5; i++) cycle(0, '0, 0);
        chk("rst_valid", valid_o, 1'b0);
        chk("rst_ready", ready_o, 1'b1);
        chk("rst_credits", credits_o, 4'd3);
        chk("rst_sent", sent_cnt_o, 32'd0);
        chk("rst_err", err_o, 1'b0);

        // Credit exhaustion followed by full-FIFO backpressure
        for (int i = 0; i < 17; i++) begin
            cycle(tbl[i].v, tbl[i].d, tbl[i].y);
            chk($sformatf("tbl%0d_valid", i), valid_o, tbl[i].ev);
            chk($sformatf("tbl%0d_data", i), data_o, tbl[i].ed);
            chk($sformatf("tbl%0d_credits", i), credits_o, tbl[i].ec);
            chk($sformatf("tbl%0d_sent", i), sent_cnt_o, tbl[i].es);
            chk($sformatf("tbl%0d_ready", i), ready_o, tbl[i].er);
        end
        for (int i = 0; i < 8; i++) cycle(0, '0, (i % 2) == 0);
        chk("drain_sent", sent_cnt_o, 32'd8);

        // Steady stream: yummy returned one cycle after each valid_o
        do_reset();
        pushed = 0; got = 0; gaps = 0; started = 0;
        for (int c = 0; c < 300 && got < 100; c++) begin
            bit v;
            v = (pushed < 100);
            if (v && ready_o) pushed++;
            cycle(v, 64'h5000 + 64'(pushed - int'(v)), valid_o);
            if (valid_o) begin
                chk("stream_order", data_o, 64'h5000 + 64'(got));
                chk("stream_credits", credits_o, 4'd2);
                got++;
                started = 1;
            end else if (started && got < 100) begin
                gaps++;
            end
        end
        chk("stream_count", got, 100);
        chk("stream_gaps", gaps, 0);
        chk("stream_sent", sent_cnt_o, 32'd100);
        for (int i = 0; i < 3; i++) cycle(0, '0, valid_o);
        chk("stream_cred_back", credits_o, 4'd3);
        chk("stream_no_err", err_o, 1'b0);

        // Credit overflow is sticky until reset
        do_reset();
        cycle(0, '0, 1);
        chk("ovf_credits", credits_o, 4'd3);
        chk("ovf_err", err_o, 1'b1);
        for (int i = 0; i < 6; i++) cycle(i < 3, 64'hC0 + 64'(i), i >= 3);
        chk("ovf_err_sticky", err_o, 1'b1);
        do_reset();
        chk("ovf_err_cleared", err_o, 1'b0);

        // Reset while two flits are buffered and one credit remains
        for (int i = 0; i < 5; i++) cycle(1, 64'hD0 + 64'(i), 0);
        cycle(0, '0, 1);
        cycle(1, 64'hD5, 1);
        chk("mid_valid_before", valid_o, 1'b1);
        chk("mid_credits_before", credits_o, 4'd1);
        #2;
        rstn_i = 1'b0;
        valid_i = 1'b0;
        yummy_i = 1'b0;
        #1;
        chk("mid_valid_async", valid_o, 1'b0);
        chk("mid_credits_async", credits_o, 4'd3);
        chk("mid_ready_async", ready_o, 1'b1);
        chk("mid_sent_async", sent_cnt_o, 32'd0);
        model_reset();
        @(negedge clk_i);
        rstn_i = 1'b1;
        @(posedge clk_i);
        #1;
        for (int i = 0; i < 5; i++) begin
            cycle(0, '0, 0);
            chk("mid_no_stale", valid_o, 1'b0);
        end

        // Randomized traffic against the model
        do_reset();
        for (int i = 0; i < 600; i++)
            cycle($urandom_range(0, 3) != 0, {$urandom, $urandom}, $urandom_range(0, 2) == 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/mpi_credit_tx.md
# mpi_credit_tx

Credit-based flit transmitter that sits directly upstream of the MPI fake-node bridge. It accepts 64-bit flits from a local producer through a valid/ready handshake and buffers them in a small FIFO. It drives them onto the node-facing valid/data channel, spending one credit per flit, and a credit is returned each time the far side pulses yummy. It replaces the free-running flit source with a flow-controlled one, so no flit is ever sent without a downstream buffer slot.

## Interface
Parameters:
- DATA_W, 64, flit width.
- FIFO_DEPTH, 4, buffer entries; power of two, at least 2.
- CREDITS, 3, initial and maximum credit count; range 1..15.

Ports:
- clk_i  in  1  clock, rising edge.
- rstn_i  in  1  reset, asynchronous, active-low.
- valid_i  in  1  producer flit valid.
- data_i  in  DATA_W  producer flit.
- ready_o  out  1  FIFO can accept a flit this cycle.
- valid_o  out  1  flit valid toward the bridge; registered.
- data_o  out  DATA_W  flit toward the bridge; registered.
- yummy_i  in  1  one-cycle credit return pulse from the bridge.
- credits_o  out  4  current credit count.
- sent_cnt_o  out  32  total flits sent; wraps at 2^32.
- err_o  out  1  sticky credit-overflow error.

## Operation
- **Push.** A flit is pushed when valid_i && ready_o. ready_o = !full, combinational from the FIFO count. Data_i is ignored when valid_i is low.
- **FIFO.** Circular buffer with rd/wr pointers of log2(FIFO_DEPTH) bits and a count register of log2(FIFO_DEPTH)+1 bits. Pointers wrap modulo FIFO_DEPTH.
- **Send condition.** send = (count != 0) && (credits != 0), evaluated on registered state only. When send is true:
  - the head is popped;
  - data_o <= head;
  - valid_o <= 1;
  - sent_cnt_o increments.
  Otherwise valid_o <= 0 and data_o holds its last value.
- **Credit update.** credits_next = credits - send + yummy_i.
  - yummy_i arriving in the same cycle as a send: net change is 0.
  - yummy_i arriving when credits == CREDITS and no send this cycle: the count stays at CREDITS, the pulse is dropped, and err_o is set to 1. err_o stays 1 until reset.
  - A yummy does not enable a send in the same cycle; it is usable from the next cycle.
- **Simultaneous push and pop.** Legal in any state except full. When full, ready_o = 0, so only a pop can occur; ready_o rises the cycle after that pop.
- **Empty.** A push into an empty FIFO is never sent in the same cycle.
- **Counter width.** sent_cnt_o is unsigned and wraps from 0xFFFF_FFFF to 0.
- **States.** The FIFO state is implicit in count: EMPTY (0), PARTIAL, FULL (FIFO_DEPTH). The credit state is STALLED (credits = 0) or ACTIVE.

## Timing
- **Reset values** (asynchronous, all outputs):
  - valid_o = 0, data_o = 0;
  - credits_o = CREDITS, sent_cnt_o = 0, err_o = 0;
  - FIFO count and pointers = 0, so ready_o = 1.
- **Latency.** A flit accepted at edge E appears with valid_o = 1 after edge E+1 at the earliest, i.e. 1 cycle of buffering plus the registered output.
- **Throughput.** 1 flit/cycle while credits > 0 and the FIFO is non-empty.
- **Credit-stall recovery.** A yummy_i pulse at edge E makes credits 1 after E; the next valid_o rises after E+1.
- **Reset mid-operation.** Buffered flits are discarded, credits return to CREDITS, and no partial output is held. valid_o drops immediately on rstn_i falling, not at the next edge.
- **valid_o pulse width.** valid_o is a one-cycle pulse per flit. Back-to-back flits give valid_o high on consecutive cycles.

## Test plan
1. **Reset check.** Reset, then apply no stimulus for 5 cycles. Required:
   - valid_o = 0, ready_o = 1, credits_o = 3, sent_cnt_o = 0, err_o = 0.
2. **Credit exhaustion.** Push 0xA0..0xA3 on 4 consecutive cycles with yummy_i = 0. Required:
   - valid_o pulses 3 times with data 0xA0, 0xA1, 0xA2 in order;
   - credits_o then = 0, and 0xA3 stays buffered;
   - one yummy_i pulse releases 0xA3 two cycles later and sent_cnt_o = 4.
3. **Full FIFO.** With CREDITS held at 0 (start from scenario 2 drained, no yummy), push 4 flits. Required:
   - ready_o = 0 after the 4th push, and a 5th valid_i is not accepted;
   - one yummy_i: after the pop, ready_o = 1 the following cycle.
4. **Steady stream.** Keep valid_i = 1 and return yummy_i every cycle, one cycle after each valid_o, for 100 flits. Required:
   - 100 valid_o cycles, data in order, no gaps after startup;
   - credits_o stays constant and sent_cnt_o = 100.
5. **Credit overflow.** From reset, pulse yummy_i with the FIFO empty. Required:
   - credits_o stays 3 and err_o = 1;
   - err_o remains 1 after later normal traffic until rstn_i is asserted.
6. **Reset mid-operation.** Assert rstn_i low while 2 flits are buffered and credits = 1. Required:
   - valid_o = 0 immediately;
   - after release: credits_o = 3, ready_o = 1, and no stale flit is emitted.
